// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl -- machine-mode trap controller for the 3-stage pipeline.
//
// Sits in front of the CSR register file. Each cycle it looks at the
// instruction in execute and decides, in priority order, between an illegal
// instruction, an ecall, an mret, an external interrupt and a machine-timer
// interrupt. A decision kills the execute instruction combinationally (except
// mret, which retires), then one cycle later pulses the CSR trap-entry or
// mret request together with a PC redirect to the handler or back to mepc.
//
// Optional feature: define TRAP_TIMER_EN to build the 64-bit mtime/mtimecmp
// timer. Without it the timer is absent: mtip_o=0, tmr_rdata_o=0, timer
// writes are dropped and the timer cause never occurs. Ports do not change.
//
// Parameters
//   RESET_PC     redirect_pc_o value out of reset
//   SYNC_STAGES  flops in the ext_irq_i synchroniser (2..3)
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   ext_irq_i                  level external interrupt, asynchronous to clk
//   mstatus_mie_i              global machine interrupt enable
//   mie_meie_i, mie_mtie_i     external / timer interrupt enables
//   mtvec_i, mepc_i            trap vector (mode in [1:0]) and current mepc
//   ex_valid_i, ex_pc_i        execute-stage valid and PC
//   illegal_i, ecall_i, mret_i decode flags of the execute instruction
//   tmr_we_i/addr_i/wdata_i    timer register write port
//   tmr_rdata_o                combinational timer register read
//   kill_ex_o                  suppress writeback of execute (same cycle)
//   csr_trap_we_o              trap-entry pulse, with csr_mepc_o/csr_mcause_o
//   csr_mret_o                 mret pulse
//   redirect_o, redirect_pc_o  fetch redirect pulse and target
//   mtip_o                     timer interrupt pending (mtime >= mtimecmp)
// ---------------------------------------------------------------------------
module trap_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_irq_i,
  input  logic        mstatus_mie_i,
  input  logic        mie_meie_i,
  input  logic        mie_mtie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        illegal_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        tmr_we_i,
  input  logic [1:0]  tmr_addr_i,
  input  logic [31:0] tmr_wdata_i,
  output logic [31:0] tmr_rdata_o,
  output logic        kill_ex_o,
  output logic        csr_trap_we_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o,
  output logic        csr_mret_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        mtip_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REDIR = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TMR_IRQ = 32'h8000_0007;

  // -------------------------------------------------------------------------
  // External interrupt synchroniser
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] irq_sync_q;
  logic                   irq_sync;

  // NOTE: every flop in this file is updated with non-blocking assignments so
  // all registers sample the same pre-edge values; blocking here would let a
  // stage see its neighbour's new value and collapse the synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_sync_q <= '0;
    end else begin
      irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], ext_irq_i};
    end
  end

  assign irq_sync = irq_sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Machine timer
  // -------------------------------------------------------------------------
  logic mtip;

`ifdef TRAP_TIMER_EN
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;

  // NOTE: combinational blocks assign a default to every output first, so no
  // path through the case statements leaves a signal unassigned (no latch).
  always_comb begin
    mtime_d    = mtime_q + 64'd1;  // free-running, wraps naturally at 2^64
    mtimecmp_d = mtimecmp_q;
    if (tmr_we_i) begin
      case (tmr_addr_i)
        2'd0:    mtimecmp_d[31:0]  = tmr_wdata_i;
        2'd1:    mtimecmp_d[63:32] = tmr_wdata_i;
        // A software write to mtime replaces this cycle's increment.
        2'd2:    mtime_d = {mtime_q[63:32], tmr_wdata_i};
        default: mtime_d = {tmr_wdata_i, mtime_q[31:0]};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign mtip = (mtime_q >= mtimecmp_q);

  always_comb begin
    tmr_rdata_o = '0;
    case (tmr_addr_i)
      2'd0:    tmr_rdata_o = mtimecmp_q[31:0];
      2'd1:    tmr_rdata_o = mtimecmp_q[63:32];
      2'd2:    tmr_rdata_o = mtime_q[31:0];
      default: tmr_rdata_o = mtime_q[63:32];
    endcase
  end
`else
  // Timer absent: write port is accepted but has no effect.
  logic unused_tmr;
  assign unused_tmr  = ^{tmr_we_i, tmr_addr_i, tmr_wdata_i};
  assign mtip        = 1'b0;
  assign tmr_rdata_o = '0;
`endif

  assign mtip_o = mtip;

  // -------------------------------------------------------------------------
  // Trap arbitration
  // -------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic        eval_en;
  logic        ext_pend, tmr_pend;
  logic        take_trap, take_mret;
  logic [31:0] cause;
  logic [31:0] trap_base, trap_target;

  // REDIR is the only state that ignores the execute stage; HOLD evaluates
  // its first valid instruction exactly like IDLE.
  assign eval_en  = ex_valid_i && (state_q != ST_REDIR);
  assign ext_pend = mstatus_mie_i & mie_meie_i & irq_sync;
  assign tmr_pend = mstatus_mie_i & mie_mtie_i & mtip;

  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    cause     = '0;
    if (eval_en) begin
      if (illegal_i) begin
        take_trap = 1'b1;
        cause     = CAUSE_ILLEGAL;
      end else if (ecall_i) begin
        take_trap = 1'b1;
        cause     = CAUSE_ECALL;
      end else if (mret_i) begin
        // mret outranks interrupts; a pending one is taken after the return.
        take_mret = 1'b1;
      end else if (ext_pend) begin
        take_trap = 1'b1;
        cause     = CAUSE_EXT_IRQ;
      end else if (tmr_pend) begin
        take_trap = 1'b1;
        cause     = CAUSE_TMR_IRQ;
      end
    end
  end

  assign kill_ex_o = take_trap;

  // Vectored mode offsets only interrupts; exceptions always use the base.
  assign trap_base   = {mtvec_i[31:2], 2'b00};
  assign trap_target = ((mtvec_i[1:0] == 2'b01) && cause[31])
                     ? trap_base + {25'd0, cause[4:0], 2'b00}
                     : trap_base;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (take_trap || take_mret) state_d = ST_REDIR;
      ST_REDIR: state_d = ST_HOLD;
      ST_HOLD:  if (ex_valid_i) state_d = (take_trap || take_mret) ? ST_REDIR : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered CSR requests and redirect
  // -------------------------------------------------------------------------
  logic        trap_we_q, trap_we_d;
  logic        mret_q, mret_d;
  logic        redirect_q, redirect_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  always_comb begin
    trap_we_d     = take_trap;
    mret_d        = take_mret;
    redirect_d    = take_trap | take_mret;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    redirect_pc_d = redirect_pc_q;
    if (take_trap) begin
      // Interrupts also record the killed PC so it re-executes on return.
      mepc_d        = ex_pc_i;
      mcause_d      = cause;
      redirect_pc_d = trap_target;
    end else if (take_mret) begin
      redirect_pc_d = mepc_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      trap_we_q     <= 1'b0;
      mret_q        <= 1'b0;
      redirect_q    <= 1'b0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      redirect_pc_q <= RESET_PC;
    end else begin
      state_q       <= state_d;
      trap_we_q     <= trap_we_d;
      mret_q        <= mret_d;
      redirect_q    <= redirect_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign csr_trap_we_o = trap_we_q;
  assign csr_mret_o    = mret_q;
  assign redirect_o    = redirect_q;
  assign csr_mepc_o    = mepc_q;
  assign csr_mcause_o  = mcause_q;
  assign redirect_pc_o = redirect_pc_q;

endmodule
